matrix_feeder: RTL and testbench
================================

# matrix_feeder

Host-side producer/consumer for the matrix processor. Accepts a byte stream carrying the dimension N and then N×N operand elements. Pushes the elements into the operand FIFO and pulses `start` to the processor controller. It then pops N results from the result FIFO and returns them on a valid/ready output stream. It sits between the host link and the two processor FIFOs, and works the opposite FIFO ends from the processor controller: it pushes operands the controller pops, and pops results the controller pushes.

## Interface
Parameters:
- `DW`, 8: operand element width; equals input byte width.
- `RW`, 16: result word width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `in_valid`  in  1  host byte valid.
- `in_data`  in  DW  host byte.
- `in_ready`  out  1  feeder accepts `in_data` this cycle.
- `op_push`  out  1  write strobe to the operand FIFO.
- `op_data`  out  DW  operand FIFO write data.
- `op_full`  in  1  operand FIFO full.
- `start`  out  1  one-cycle pulse to the processor controller.
- `N`  out  3  latched dimension, held stable from `start` until `done`.
- `res_pop`  out  1  read strobe to the result FIFO (show-ahead).
- `res_data`  in  RW  result FIFO head, valid while `!res_empty`.
- `res_empty`  in  1  result FIFO empty.
- `out_valid`  out  1  result word valid.
- `out_data`  out  RW  result word.
- `out_ready`  in  1  host accepts the result word.
- `done`  out  1  one-cycle pulse after the last result has been accepted.

## Operation
- States: `IDLE`, `FILL`, `KICK`, `DRAIN`, `FIN`.
- `IDLE`
  - `in_ready=1`.
  - On `in_valid`, latch `N<=in_data[2:0]` and clear the element counter.
  - If `in_data[2:0]==0`, discard the byte and stay in `IDLE`.
  - Otherwise go to `FILL`.
- `FILL`
  - `in_ready = !op_full`.
  - `op_push = in_valid & in_ready`, combinational in the same cycle; `op_data = in_data`.
  - Each push increments the element counter.
  - On the push that makes the count equal to N·N, go to `KICK`.
- `KICK`
  - `start=1` for exactly one cycle.
  - Clear the result counter.
  - Go to `DRAIN`.
- `DRAIN`
  - One-entry output register.
  - `res_pop = !res_empty & (!out_valid | out_ready) & (popped < N)`.
  - On pop: `out_data<=res_data`, `out_valid<=1`, popped count +1.
  - On `out_valid & out_ready` with no pop: `out_valid<=0`.
  - The accepted-results counter increments on each `out_valid & out_ready`.
  - When N results have been accepted, go to `FIN`.
- `FIN`: `done=1` for one cycle, then go to `IDLE`.
- `in_ready=0` in `KICK`, `DRAIN` and `FIN`. Host bytes arriving then are not consumed.
- Arithmetic:
  - N·N is computed from the 3-bit N into a 6-bit target (max 49).
  - Element counter is 6 bits; result counters are 3 bits.
  - No wrap is possible within a transaction.

## Timing
- Reset values (`rst` high at a clock edge):
  - State `IDLE`.
  - `N=0`.
  - All counters 0.
  - `out_valid=0`, `out_data=0`.
  - `in_ready` follows `IDLE`, so it is 1 once the reset edge has completed.
  - `op_push`, `start`, `res_pop` and `done` are all 0.
- Reset mid-transaction aborts immediately: no further push or pop, and no `start` or `done`. FIFO contents are not flushed by this block.
- Push latency: 0 cycles (combinational from `in_valid`). `op_full` asserted means there is no push and the byte is held by the host.
- `start` is asserted the cycle after the final push.
- Result latency: `out_valid` rises the cycle after `res_pop`.
- Sustained throughput is 1 word/cycle with `out_ready` held high.
- `out_data` is held stable while `out_valid & !out_ready`.
- Simultaneous accept and pop in the same cycle: the new word replaces the old one and `out_valid` stays 1.
- `done` is asserted the cycle after the N-th accept.

## Structure
- `processor_pkg` gains:
  - `FEED_STATE_e` enum with the five states.
  - `elem_count_t` (6-bit).
  - `res_count_t` (3-bit).
  - Constants `FEED_DW=8` and `FEED_RW=16`.
- One sub-module, `result_out_reg`: the valid/ready one-entry output register with load/accept logic. Everything else stays in `matrix_feeder`.

## Test plan
- Basic run
  - Stimulus: N=2 byte, then 4 elements (1,2,3,4) back-to-back. Host holds `out_ready=1`.
  - Required: 4 `op_push` cycles with data 1,2,3,4; `start` pulse the next cycle.
  - After the result FIFO is preloaded with 10,20: `out_data` 10 then 20 on consecutive cycles, then `done`.
- Zero dimension
  - Stimulus: N byte 0x08 (low bits 0), then 0x03.
  - Required: the first byte is discarded and the feeder stays in `IDLE`; N=3; the next 9 bytes are pushed.
- Operand backpressure
  - Stimulus: `op_full` high for 3 cycles during the 2nd element.
  - Required: `in_ready=0` and no push during those cycles; element order is preserved; `start` is asserted only after the 9th push (N=3).
- Output backpressure
  - Stimulus: N=3, `out_ready` toggling 0/1.
  - Required: `out_data` is held while stalled; never more than 3 pops; `done` is asserted exactly once after the 3rd accept.
- Mid-transaction reset
  - Stimulus: `rst` pulse after 5 of 9 pushes.
  - Required: no `start`; state `IDLE`; a fresh N=1 transaction then completes normally.
- Maximum dimension
  - Stimulus: N=7.
  - Required: exactly 49 pushes before `start`; 7 results drained.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared types and constants for the matrix processor and its host-side feeder.
package processor_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    KICK  = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } FEED_STATE_e;

  typedef logic [5:0] elem_count_t;
  typedef logic [2:0] res_count_t;

  localparam int FEED_DW = 8;
  localparam int FEED_RW = 16;

  // Element count of an N x N operand block; 7*7 = 49 fits in 6 bits.
  function automatic elem_count_t dim_square(input logic [2:0] n);
    elem_count_t n_ext;
    n_ext = {3'b000, n};
    return n_ext * n_ext;
  endfunction

endpackage

// File: rtl/result_out_reg.sv
// One-entry valid/ready output register: a load replaces the held word,
// an accept without a load empties it.
module result_out_reg #(
  parameter int RW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [RW-1:0] load_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [RW-1:0] out_data,
  output logic          accept
);

  logic          valid_r;
  logic [RW-1:0] data_r;

  // Output word and its valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= {RW{1'b0}};
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
    end else if (valid_r && out_ready) begin
      valid_r <= 1'b0;
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign accept    = valid_r & out_ready;

endmodule

// File: rtl/matrix_feeder.sv
// Host-side feeder: streams N x N operands into the operand FIFO, kicks the
// processor, then drains N results onto a valid/ready output stream.
module matrix_feeder
  import processor_pkg::*;
#(
  parameter int DW = FEED_DW,
  parameter int RW = FEED_RW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          op_push,
  output logic [DW-1:0] op_data,
  input  logic          op_full,
  output logic          start,
  output logic [2:0]    N,
  output logic          res_pop,
  input  logic [RW-1:0] res_data,
  input  logic          res_empty,
  output logic          out_valid,
  output logic [RW-1:0] out_data,
  input  logic          out_ready,
  output logic          done
);

  FEED_STATE_e state_r, state_s;
  logic [2:0]  n_r;
  elem_count_t elem_cnt_r;
  elem_count_t target_s;
  res_count_t  popped_r;
  res_count_t  accepted_r;

  logic in_ready_s, op_push_s, start_s, res_pop_s, done_s, accept_s;

  assign target_s = dim_square(n_r);

  // Next-state and strobe decode.
  always_comb begin
    state_s    = state_r;
    in_ready_s = 1'b0;
    op_push_s  = 1'b0;
    start_s    = 1'b0;
    res_pop_s  = 1'b0;
    done_s     = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        if (in_valid && (in_data[2:0] != 3'd0)) begin
          state_s = FILL;
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        in_ready_s = !op_full;
        op_push_s  = in_valid && !op_full;
        if (op_push_s && ((elem_cnt_r + 6'd1) == target_s)) begin
          state_s = KICK;
        end else begin
          state_s = FILL;
        end
      end
      KICK: begin
        start_s = 1'b1;
        state_s = DRAIN;
      end
      DRAIN: begin
        res_pop_s = !res_empty && (!out_valid || out_ready) && (popped_r < n_r);
        if (accept_s && ((accepted_r + 3'd1) == n_r)) begin
          state_s = FIN;
        end else begin
          state_s = DRAIN;
        end
      end
      FIN: begin
        done_s  = 1'b1;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, latched dimension and transaction counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      n_r        <= 3'd0;
      elem_cnt_r <= 6'd0;
      popped_r   <= 3'd0;
      accepted_r <= 3'd0;
    end else begin
      state_r <= state_s;
      if ((state_r == IDLE) && in_valid) begin
        n_r        <= in_data[2:0];
        elem_cnt_r <= 6'd0;
      end
      if (op_push_s) begin
        elem_cnt_r <= elem_cnt_r + 6'd1;
      end
      if (start_s) begin
        popped_r   <= 3'd0;
        accepted_r <= 3'd0;
      end
      if (res_pop_s) begin
        popped_r <= popped_r + 3'd1;
      end
      if (accept_s) begin
        accepted_r <= accepted_r + 3'd1;
      end
    end
  end

  result_out_reg #(.RW(RW)) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (res_pop_s),
    .load_data (res_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .accept    (accept_s)
  );

  // Reset abandons the transaction in the same cycle: no handshake escapes.
  assign in_ready = in_ready_s & ~rst;
  assign op_push  = op_push_s & ~rst;
  assign op_data  = in_data;
  assign start    = start_s & ~rst;
  assign res_pop  = res_pop_s & ~rst;
  assign done     = done_s & ~rst;
  assign N        = n_r;

endmodule

// File: tb/tb_matrix_feeder.sv
// Directed bench for matrix_feeder with a show-ahead result FIFO model.
module tb_matrix_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        op_push;
  logic [7:0]  op_data;
  logic        op_full;
  logic        start;
  logic [2:0]  N;
  logic        res_pop;
  logic [15:0] res_data;
  logic        res_empty;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        done;

  always #5 clk = ~clk;

  matrix_feeder #(.DW(8), .RW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .op_push(op_push), .op_data(op_data),
    .op_full(op_full), .start(start), .N(N), .res_pop(res_pop),
    .res_data(res_data), .res_empty(res_empty), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .done(done)
  );

  // Result FIFO model (show-ahead)
  logic [15:0] res_mem [0:255];
  int rd_ptr = 0;
  int wr_ptr = 0;
  bit pop_pend = 1'b0;
  assign res_empty = (rd_ptr == wr_ptr);
  assign res_data  = res_mem[rd_ptr % 256];

  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pop_pend) rd_ptr <= rd_ptr + 1;
  end

  // Event log, captured mid-cycle
  logic [7:0]  push_log [0:63];
  logic [15:0] acc_log  [0:7];
  int push_cnt, start_cnt, pop_cnt, acc_cnt, done_cnt;
  int last_push_cyc, start_cyc, first_acc_cyc, last_acc_cyc, done_cyc;
  int full_viol, hold_viol;
  logic [2:0]  start_n, done_n;
  bit          hold_pend;
  logic [15:0] hold_val;

  always @(negedge clk) begin
    pop_pend = res_pop;
    if (!rst) begin
      if (op_push) begin
        if (push_cnt < 64) push_log[push_cnt] = op_data;
        push_cnt++;
        last_push_cyc = cyc;
      end
      if (start) begin
        start_cnt++;
        start_cyc = cyc;
        start_n = N;
      end
      if (res_pop) pop_cnt++;
      if (out_valid && out_ready) begin
        if (acc_cnt < 8) acc_log[acc_cnt] = out_data;
        if (acc_cnt == 0) first_acc_cyc = cyc;
        acc_cnt++;
        last_acc_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_n = N;
      end
      if (op_full && in_valid && (in_ready || op_push)) full_viol++;
      if (hold_pend && (out_data != hold_val)) hold_viol++;
      hold_pend = out_valid && !out_ready;
      hold_val  = out_data;
    end else begin
      hold_pend = 1'b0;
    end
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    push_cnt = 0; start_cnt = 0; pop_cnt = 0; acc_cnt = 0; done_cnt = 0;
    last_push_cyc = -10; start_cyc = -20; first_acc_cyc = -30;
    last_acc_cyc = -40; done_cyc = -50;
    full_viol = 0; hold_viol = 0; hold_pend = 1'b0;
    start_n = 3'd0; done_n = 3'd0;
    for (int i = 0; i < 64; i++) push_log[i] = 8'hEE;
    for (int i = 0; i < 8; i++) acc_log[i] = 16'hDEAD;
  endtask

  // Offer one byte until accepted, optionally holding op_full first.
  task automatic send_byte(input logic [7:0] b, input int stall);
    bit got;
    in_valid = 1'b1;
    in_data  = b;
    repeat (stall) begin
      op_full = 1'b1;
      @(posedge clk); #1;
    end
    op_full = 1'b0;
    got = 1'b0;
    for (int w = 0; w < 50 && !got; w++) begin
      #1;
      got = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    if (!got) check("in_ready timeout", 32'(got), 32'd1);
  endtask

  typedef struct {
    logic [7:0] n_byte;
    int         stall_elem;
    int         stall_len;
    bit         tog;
    logic [2:0] exp_n;
  } vec_t;

  task automatic run_txn(input vec_t t, input int k);
    int n, nn;
    n  = int'(t.exp_n);
    nn = n * n;
    clear_logs();
    for (int j = 0; j < n; j++) begin
      res_mem[wr_ptr % 256] = 16'(k * 1000 + 10 * (j + 1));
      wr_ptr++;
    end
    out_ready = 1'b1;
    send_byte(t.n_byte, 0);
    for (int i = 0; i < nn; i++)
      send_byte(8'(k * 16 + i + 1), (i == t.stall_elem) ? t.stall_len : 0);
    for (int c = 0; c < 400 && done_cnt == 0; c++) begin
      out_ready = t.tog ? (c % 2 == 1) : 1'b1;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("push count", 32'(push_cnt), 32'(nn));
    for (int i = 0; i < nn; i++)
      check("push data", 32'(push_log[i]), 32'(8'(k * 16 + i + 1)));
    check("start count", 32'(start_cnt), 32'd1);
    check("start timing", 32'(start_cyc), 32'(last_push_cyc + 1));
    check("N at start", 32'(start_n), 32'(t.exp_n));
    check("pop count", 32'(pop_cnt), 32'(n));
    check("accept count", 32'(acc_cnt), 32'(n));
    for (int j = 0; j < n; j++)
      check("result data", 32'(acc_log[j]), 32'(16'(k * 1000 + 10 * (j + 1))));
    check("done count", 32'(done_cnt), 32'd1);
    check("done timing", 32'(done_cyc), 32'(last_acc_cyc + 1));
    check("N at done", 32'(done_n), 32'(t.exp_n));
    check("op_full respected", 32'(full_viol), 32'd0);
    check("out_data held", 32'(hold_viol), 32'd0);
    check("result fifo drained", 32'(res_empty), 32'd1);
    if (!t.tog) check("back-to-back results", 32'(last_acc_cyc - first_acc_cyc), 32'(n - 1));
  endtask

  vec_t vecs [0:4];

  initial begin
    vecs[0] = '{8'h02, -1, 0, 1'b0, 3'd2};  // basic run
    vecs[1] = '{8'h03,  1, 3, 1'b0, 3'd3};  // operand backpressure
    vecs[2] = '{8'h03, -1, 0, 1'b1, 3'd3};  // output backpressure
    vecs[3] = '{8'h07, -1, 0, 1'b0, 3'd7};  // maximum dimension
    vecs[4] = '{8'h81, -1, 0, 1'b0, 3'd1};  // upper bits ignored

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; op_full = 1'b0; out_ready = 1'b1;
    clear_logs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset N", 32'(N), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset op_push", 32'(op_push), 32'd0);
    check("reset start", 32'(start), 32'd0);
    check("reset res_pop", 32'(res_pop), 32'd0);
    check("reset done", 32'(done), 32'd0);

    for (int v = 0; v < 5; v++) run_txn(vecs[v], v);

    // Zero dimension byte is dropped; the next byte carries N.
    clear_logs();
    send_byte(8'h08, 0);
    #1;
    check("zero dim N", 32'(N), 32'd0);
    check("zero dim in_ready", 32'(in_ready), 32'd1);
    check("zero dim pushes", 32'(push_cnt), 32'd0);
    run_txn('{8'h03, -1, 0, 1'b0, 3'd3}, 5);

    // Reset after 5 of 9 operands.
    clear_logs();
    send_byte(8'h03, 0);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + i), 0);
    check("pre-reset pushes", 32'(push_cnt), 32'd5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort N", 32'(N), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort out_valid", 32'(out_valid), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("abort start", 32'(start_cnt), 32'd0);
    check("abort pushes", 32'(push_cnt), 32'd5);
    run_txn('{8'h01, -1, 0, 1'b0, 3'd1}, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
